// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction buffer between IF and ID. Holds up to DEPTH {pc, inst} entries
//   so fetch can keep running while decode stalls. A redirect (flush) discards
//   everything buffered and adds the number of discarded entries to a
//   saturating drop counter. With BYPASS=1 an instruction offered to an empty
//   queue while ID is ready goes straight through without being written.
//
// Ports
//   clk                in   rising-edge clock
//   rst                in   asynchronous reset, active-high
//   i_fs_valid         in   IF presents an instruction
//   i_fs_pc            in   pc of the presented instruction
//   i_fs_inst          in   presented instruction
//   o_fq_allowin       out  queue can accept this cycle (registered count only)
//   i_flush            in   redirect: discard all contents
//   i_ds_allowin       in   ID accepts this cycle
//   o_fq_to_ds_valid   out  head entry valid towards ID
//   o_fq_if_id_bus     out  {pc, inst} of head entry, 0 when not valid
//   o_fq_count         out  occupied entries
//   o_fq_drop_cnt      out  saturating count of entries dropped by flush
// ----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int unsigned DEPTH  = 4,  // power of 2, >= 2
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_fs_valid,
  input  logic [PC_W-1:0]            i_fs_pc,
  input  logic [INST_W-1:0]          i_fs_inst,
  output logic                       o_fq_allowin,
  input  logic                       i_flush,
  input  logic                       i_ds_allowin,
  output logic                       o_fq_to_ds_valid,
  output logic [PC_W+INST_W-1:0]     o_fq_if_id_bus,
  output logic [$clog2(DEPTH+1)-1:0] o_fq_count,
  output logic [7:0]                 o_fq_drop_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = PC_W + INST_W;
  // Wide enough to hold 255 + DEPTH without wrapping.
  localparam int unsigned SUM_W   = (CNT_W > 8) ? CNT_W + 1 : 9;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_drop_cnt;

  logic               w_empty;
  logic               w_full;
  logic               w_valid;
  logic [ENTRY_W-1:0] w_bus;
  logic               w_bypass_take;
  logic               w_push;
  logic               w_pop;
  logic [SUM_W-1:0]   w_drop_sum;
  logic [7:0]         w_drop_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Head selection. The valid is gated by rst so the async reset clears the
  // outputs immediately even when the bypass path would otherwise be live.
  always_comb begin
    w_valid = 1'b0;
    w_bus   = '0;
    if (!rst && !i_flush) begin
      if (!w_empty) begin
        w_valid = 1'b1;
        w_bus   = r_mem[r_rd_ptr];
      end else if (BYPASS != 0) begin
        w_valid = i_fs_valid;
        w_bus   = i_fs_valid ? {i_fs_pc, i_fs_inst} : '0;
      end
    end
  end

  // An instruction consumed through the bypass must not also be written.
  assign w_bypass_take = (BYPASS != 0) && w_empty && i_fs_valid && !i_flush && i_ds_allowin;
  assign w_push        = i_fs_valid && !w_full && !i_flush && !w_bypass_take;
  assign w_pop         = w_valid && i_ds_allowin && !w_empty;

  assign w_drop_sum  = SUM_W'(r_drop_cnt) + SUM_W'(r_count);
  assign w_drop_next = (w_drop_sum > SUM_W'(255)) ? 8'd255 : w_drop_sum[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else if (i_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= w_drop_next;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; only entries below r_count are read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_fs_pc, i_fs_inst};
  end

  assign o_fq_allowin     = !w_full;
  assign o_fq_to_ds_valid = w_valid;
  assign o_fq_if_id_bus   = w_bus;
  assign o_fq_count       = r_count;
  assign o_fq_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: one BYPASS=0 and one BYPASS=1 instance share the
// same stimulus. A queue-based model predicts every output; directed scenarios
// also check hand-computed literals.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        flush;
  logic        ds_allowin;

  logic        a0, a1, v0, v1;
  logic [63:0] b0, b1;
  logic [2:0]  c0, c1;
  logic [7:0]  d0, d1;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq [2][$];
  int          mdrop [2];

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(0)) u_reg (
    .clk(clk), .rst(rst), .i_fs_valid(fs_valid), .i_fs_pc(fs_pc), .i_fs_inst(fs_inst),
    .o_fq_allowin(a0), .i_flush(flush), .i_ds_allowin(ds_allowin),
    .o_fq_to_ds_valid(v0), .o_fq_if_id_bus(b0), .o_fq_count(c0), .o_fq_drop_cnt(d0)
  );

  if_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .i_fs_valid(fs_valid), .i_fs_pc(fs_pc), .i_fs_inst(fs_inst),
    .o_fq_allowin(a1), .i_flush(flush), .i_ds_allowin(ds_allowin),
    .o_fq_to_ds_valid(v1), .o_fq_if_id_bus(b1), .o_fq_count(c1), .o_fq_drop_cnt(d1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update: a flush empties the queue and accumulates the drop count;
  // otherwise ID takes the head when ready, and IF's offer is stored if there is
  // room and it was not consumed directly through the bypass.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int sz;
      bit take;
      sz = mq[k].size();
      if (rst) begin
        mq[k].delete();
        mdrop[k] = 0;
      end else if (flush) begin
        mdrop[k] = (mdrop[k] + sz > 255) ? 255 : mdrop[k] + sz;
        mq[k].delete();
      end else begin
        take = (k == 1) && sz == 0 && fs_valid && ds_allowin;
        if (sz > 0 && ds_allowin) void'(mq[k].pop_front());
        if (fs_valid && sz < DEPTH && !take) mq[k].push_back({fs_pc, fs_inst});
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        int          sz;
        logic        ev;
        logic [63:0] eb;
        sz = mq[k].size();
        ev = !flush && (sz > 0 || (k == 1 && fs_valid));
        eb = !ev ? 64'd0 : (sz > 0 ? mq[k][0] : {fs_pc, fs_inst});
        chk(k ? "byp.count" : "reg.count", 64'(k ? c1 : c0), 64'(sz));
        chk(k ? "byp.allowin" : "reg.allowin", 64'(k ? a1 : a0), 64'(sz != DEPTH));
        chk(k ? "byp.valid" : "reg.valid", 64'(k ? v1 : v0), 64'(ev));
        chk(k ? "byp.bus" : "reg.bus", k ? b1 : b0, eb);
        chk(k ? "byp.drop" : "reg.drop", 64'(k ? d1 : d0), 64'(mdrop[k]));
      end
    end
  end

  // One cycle of inputs, applied just after the rising edge.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic ds, input logic fl);
    @(posedge clk);
    #1;
    fs_valid   = fv;
    fs_pc      = pc;
    fs_inst    = $urandom;
    ds_allowin = ds;
    flush      = fl;
  endtask

  initial begin
    rst = 1'b1; fs_valid = 0; fs_pc = 0; fs_inst = 0; flush = 0; ds_allowin = 0;
    #2;
    chk("rst.count", 64'(c0), 64'd0);
    chk("rst.allowin", 64'(a0), 64'd1);
    chk("rst.valid", 64'(v1), 64'd0);
    chk("rst.bus", b0, 64'd0);
    chk("rst.drop", 64'(d1), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill to DEPTH with ID stalled; a fifth offer must be refused.
    for (int i = 0; i < 4; i++) drive(1, 32'(4 * i), 0, 0);
    drive(1, 32'h10, 0, 0);
    #1;
    chk("full.count", 64'(c0), 64'd4);
    chk("full.allowin", 64'(a0), 64'd0);
    chk("full.allowin_byp", 64'(a1), 64'd0);
    // Drain: pcs 0,4,8,C on consecutive cycles; 0x10 never got in.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      #1;
      chk("drain.pc", 64'(b0[63:32]), 64'(4 * i));
      chk("drain.valid", 64'(v0), 64'd1);
    end
    drive(0, 0, 1, 0);
    #1;
    chk("drained.valid", 64'(v0), 64'd0);
    chk("drained.count", 64'(c0), 64'd0);

    // Ten sequential pcs with alternating ID readiness, across pointer wrap.
    for (int i = 0; i < 10; i++) drive(1, 32'h200 + 32'(4 * i), (i % 2) == 0, 0);
    repeat (8) drive(0, 0, 1, 0);

    // Three queued, then a flush with a new offer that must be discarded.
    for (int i = 0; i < 3; i++) drive(1, 32'h300 + 32'(4 * i), 0, 0);
    drive(1, 32'h40, 0, 1);
    #1;
    chk("flush.valid_during", 64'(v1), 64'd0);
    drive(0, 0, 1, 0);
    #1;
    chk("flush.count", 64'(c0), 64'd0);
    chk("flush.valid", 64'(v0), 64'd0);
    chk("flush.drop", 64'(d0), 64'd3);
    chk("flush.drop_byp", 64'(d1), 64'd3);

    // Bypass: same-cycle pass-through vs one-cycle latency when registered.
    drive(1, 32'h100, 1, 0);
    #1;
    chk("byp.same_valid", 64'(v1), 64'd1);
    chk("byp.same_pc", 64'(b1[63:32]), 64'h100);
    chk("reg.same_valid", 64'(v0), 64'd0);
    drive(0, 0, 0, 0);
    #1;
    chk("byp.after_count", 64'(c1), 64'd0);
    chk("reg.after_count", 64'(c0), 64'd1);
    chk("reg.after_valid", 64'(v0), 64'd1);
    chk("reg.after_pc", 64'(b0[63:32]), 64'h100);
    drive(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    drive(0, 0, 0, 1);

    // Saturate the drop counter: 70 flushes of a full queue.
    for (int n = 0; n < 70; n++) begin
      for (int i = 0; i < 4; i++) drive(1, $urandom, 0, 0);
      drive(0, 0, 0, 1);
    end
    drive(0, 0, 0, 0);
    #1;
    chk("sat.drop", 64'(d0), 64'd255);
    chk("sat.drop_byp", 64'(d1), 64'd255);

    // Asynchronous reset mid-cycle with two entries queued and IF offering.
    drive(1, 32'h500, 0, 0);
    drive(1, 32'h504, 0, 0);
    drive(1, 32'h508, 0, 0);
    #1;
    chk("pre_rst.count", 64'(c0), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst.count", 64'(c0), 64'd0);
    chk("arst.valid", 64'(v0), 64'd0);
    chk("arst.allowin", 64'(a0), 64'd1);
    chk("arst.valid_byp", 64'(v1), 64'd0);
    chk("arst.bus_byp", b1, 64'd0);
    chk("arst.drop", 64'(d0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fs_valid = 0;
    repeat (3) drive(0, 0, 1, 0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
